// File: rtl/audio_adc_rx.sv
// Codec ADC serial receiver: deserializes MSB-first BCK/LRCK audio into parallel
// left/right samples and offers one stereo frame per LRCK period on a valid/ready port.
module audio_adc_rx #(
    parameter int   DATA_WIDTH = 16,
    parameter logic LEFT_LRCK  = 1'b1,
    parameter int   MSB_DELAY  = 0
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_ADCLRCK,
    input  logic                  iAUD_ADCDAT,
    input  logic                  iREADY,
    input  logic                  iCLR_ERR,
    output logic [DATA_WIDTH-1:0] oL_DATA,
    output logic [DATA_WIDTH-1:0] oR_DATA,
    output logic                  oVALID,
    output logic                  oOVERFLOW,
    output logic                  oFRAME_ERR
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int SW = $clog2(MSB_DELAY + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [SW-1:0] SKIP_N   = SW'(MSB_DELAY);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]            bck_q, lrck_q, dat_q;
    logic [1:0]            prime_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         skip_q, skip_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic                  left_ok_q, left_ok_d;
    logic                  pub_q, pub_d;
    logic                  ferr_set_s;

    logic [DATA_WIDTH-1:0] l_data_q, l_data_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  ferr_q, ferr_d;
    logic                  pub_go_s, ovf_set_s;

    logic chain_ok_s, bck_rise_s, lrck_edge_s, new_is_left_s;

    // Edges are only trusted once s3 holds a real pin sample, so the
    // all-zero reset state of the chains cannot fake an LRCK edge.
    assign chain_ok_s    = (prime_q == 2'd3);
    assign bck_rise_s    = chain_ok_s & bck_q[1] & ~bck_q[2];
    assign lrck_edge_s   = chain_ok_s & (lrck_q[1] ^ lrck_q[2]);
    assign new_is_left_s = (lrck_q[1] == LEFT_LRCK);

    // Input synchronizer chains (bit 0 = s1, bit 1 = s2, bit 2 = s3) and priming counter.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            bck_q   <= 3'b000;
            lrck_q  <= 3'b000;
            dat_q   <= 3'b000;
            prime_q <= 2'd0;
        end else begin
            bck_q  <= {bck_q[1:0], iAUD_BCK};
            lrck_q <= {lrck_q[1:0], iAUD_ADCLRCK};
            dat_q  <= {dat_q[1:0], iAUD_ADCDAT};
            if (prime_q != 2'd3) begin
                prime_q <= prime_q + 2'd1;
            end else begin
                prime_q <= prime_q;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: every LRCK edge selects the channel named by the new level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC, ST_LEFT, ST_RIGHT: begin
                if (lrck_edge_s) begin
                    state_d = new_is_left_s ? ST_LEFT : ST_RIGHT;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // FSM outputs: bit skipping, shifting, word commit, framing check, publish request.
    always_comb begin
        cnt_d      = cnt_q;
        skip_d     = skip_q;
        sh_d       = sh_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        left_ok_d  = left_ok_q;
        pub_d      = 1'b0;
        ferr_set_s = 1'b0;
        case (state_q)
            ST_LEFT, ST_RIGHT: begin
                if (lrck_edge_s) begin
                    cnt_d  = {CW{1'b0}};
                    skip_d = {SW{1'b0}};
                    if ((cnt_q != {CW{1'b0}}) && (cnt_q != CNT_FULL)) begin
                        ferr_set_s = 1'b1;
                        left_ok_d  = 1'b0;
                    end else if (new_is_left_s) begin
                        left_ok_d = 1'b0;
                    end else begin
                        left_ok_d = left_ok_q;
                    end
                end else if (bck_rise_s) begin
                    if (skip_q != SKIP_N) begin
                        skip_d = skip_q + SW'(1);
                    end else if (cnt_q != CNT_FULL) begin
                        sh_d  = {sh_q[DATA_WIDTH-2:0], dat_q[1]};
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q != CNT_LAST) begin
                            left_ok_d = left_ok_q;
                        end else if (state_q == ST_LEFT) begin
                            hold_l_d  = sh_d;
                            left_ok_d = 1'b1;
                        end else begin
                            hold_r_d  = sh_d;
                            pub_d     = left_ok_q;
                            left_ok_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Capture datapath registers.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q     <= {CW{1'b0}};
            skip_q    <= {SW{1'b0}};
            sh_q      <= {DATA_WIDTH{1'b0}};
            hold_l_q  <= {DATA_WIDTH{1'b0}};
            hold_r_q  <= {DATA_WIDTH{1'b0}};
            left_ok_q <= 1'b0;
            pub_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            skip_q    <= skip_d;
            sh_q      <= sh_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            left_ok_q <= left_ok_d;
            pub_q     <= pub_d;
        end
    end

    assign pub_go_s  = pub_q & (~valid_q | iREADY);
    assign ovf_set_s = pub_q & valid_q & ~iREADY;

    // Output handshake and sticky flags; a set event beats a same-cycle clear.
    always_comb begin
        l_data_d = l_data_q;
        r_data_d = r_data_q;
        valid_d  = valid_q;
        if (pub_go_s) begin
            l_data_d = hold_l_q;
            r_data_d = hold_r_q;
            valid_d  = 1'b1;
        end else if (valid_q & iREADY) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        ovf_d  = ovf_set_s | (ovf_q & ~iCLR_ERR);
        ferr_d = ferr_set_s | (ferr_q & ~iCLR_ERR);
    end

    // Output registers.
    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            l_data_q <= {DATA_WIDTH{1'b0}};
            r_data_q <= {DATA_WIDTH{1'b0}};
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            l_data_q <= l_data_d;
            r_data_q <= r_data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
        end
    end

    assign oL_DATA    = l_data_q;
    assign oR_DATA    = r_data_q;
    assign oVALID     = valid_q;
    assign oOVERFLOW  = ovf_q;
    assign oFRAME_ERR = ferr_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed bench for audio_adc_rx: left-justified instance plus an I2S instance
// sharing one serial stimulus generator.
module tb_audio_adc_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, bck = 1'b0, lrck = 1'b0, dat = 1'b0, ready = 1'b1, clr = 1'b0;
    logic [15:0] l0, r0, l1, r1;
    logic v0, o0, f0, v1, o1, f1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_bck_cyc = 0;

    audio_adc_rx #(.DATA_WIDTH(16), .LEFT_LRCK(1'b1), .MSB_DELAY(0)) dut0 (
        .iCLK_18_4(clk), .iRST_N(rst_n), .iAUD_BCK(bck), .iAUD_ADCLRCK(lrck),
        .iAUD_ADCDAT(dat), .iREADY(ready), .iCLR_ERR(clr),
        .oL_DATA(l0), .oR_DATA(r0), .oVALID(v0), .oOVERFLOW(o0), .oFRAME_ERR(f0));

    audio_adc_rx #(.DATA_WIDTH(16), .LEFT_LRCK(1'b1), .MSB_DELAY(1)) dut1 (
        .iCLK_18_4(clk), .iRST_N(rst_n), .iAUD_BCK(bck), .iAUD_ADCLRCK(lrck),
        .iAUD_ADCDAT(dat), .iREADY(ready), .iCLR_ERR(clr),
        .oL_DATA(l1), .oR_DATA(r1), .oVALID(v1), .oOVERFLOW(o1), .oFRAME_ERR(f1));

    always @(posedge clk) cyc <= cyc + 1;

    // Rising-edge monitor on oVALID of both instances.
    logic pv0 = 1'b0, pv1 = 1'b0;
    int rises0 = 0, rises1 = 0, rise_cyc0 = 0, prev_rise_cyc0 = 0;
    logic [15:0] cap_l0 = 16'h0, cap_r0 = 16'h0, cap_l1 = 16'h0, cap_r1 = 16'h0;
    always @(negedge clk) begin
        if (v0 && !pv0) begin
            rises0         <= rises0 + 1;
            prev_rise_cyc0 <= rise_cyc0;
            rise_cyc0      <= cyc;
            cap_l0         <= l0;
            cap_r0         <= r0;
        end
        if (v1 && !pv1) begin
            rises1 <= rises1 + 1;
            cap_l1 <= l1;
            cap_r1 <= r1;
        end
        pv0 <= v0;
        pv1 <= v1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // One half-frame: ns BCK periods of 12 cycles, word bits in slots dly..dly+nb-1.
    task automatic half(input logic lr, input logic [15:0] w, input int dly, input int nb, input int ns);
        lrck = lr;
        for (int s = 0; s < ns; s++) begin
            if (s >= dly && s < dly + nb) dat = w[15 - (s - dly)];
            else dat = 1'b0;
            tick(6);
            bck = 1'b1;
            last_bck_cyc = cyc;
            tick(6);
            bck = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] wl, input logic [15:0] wr);
        half(1'b1, wl, 0, 16, 16);
        half(1'b0, wr, 0, 16, 16);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", v0); end
        n_cmp++; if (l0 !== 16'h0000) begin n_bad++; $display("FAIL reset_l: got %h want 0000", l0); end
        n_cmp++; if (r0 !== 16'h0000) begin n_bad++; $display("FAIL reset_r: got %h want 0000", r0); end
        n_cmp++; if (o0 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", o0); end
        n_cmp++; if (f0 !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", f0); end
        n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL reset_valid1: got %b want 0", v1); end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_latency();
        int base;
        ready = 1'b1;
        half(1'b0, 16'hFFFF, 0, 16, 16);
        base = rises0;
        frame(16'hA5C3, 16'h5A3C);
        tick(2);
        n_cmp++; if (rises0 !== base + 1) begin n_bad++; $display("FAIL lat_count: got %0d want %0d", rises0, base + 1); end
        n_cmp++; if (rise_cyc0 - last_bck_cyc !== 4) begin n_bad++; $display("FAIL lat_cycles: got %0d want 4", rise_cyc0 - last_bck_cyc); end
        n_cmp++; if (cap_l0 !== 16'hA5C3) begin n_bad++; $display("FAIL lat_l: got %h want a5c3", cap_l0); end
        n_cmp++; if (cap_r0 !== 16'h5A3C) begin n_bad++; $display("FAIL lat_r: got %h want 5a3c", cap_r0); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = rises0;
        frame(16'd0, 16'd0);
        n_cmp++; if (cap_l0 !== 16'd0 || cap_r0 !== 16'd0) begin n_bad++; $display("FAIL b2b_f0: got %h/%h want 0000/0000", cap_l0, cap_r0); end
        frame(16'd4276, 16'd4276);
        n_cmp++; if (cap_l0 !== 16'd4276 || cap_r0 !== 16'd4276) begin n_bad++; $display("FAIL b2b_f1: got %0d/%0d want 4276/4276", cap_l0, cap_r0); end
        frame(16'd8480, 16'd8480);
        n_cmp++; if (cap_l0 !== 16'd8480 || cap_r0 !== 16'd8480) begin n_bad++; $display("FAIL b2b_f2: got %0d/%0d want 8480/8480", cap_l0, cap_r0); end
        n_cmp++; if (rise_cyc0 - prev_rise_cyc0 !== 384) begin n_bad++; $display("FAIL b2b_period: got %0d want 384", rise_cyc0 - prev_rise_cyc0); end
        frame(16'd32767, 16'd32768);
        tick(2);
        n_cmp++; if (cap_l0 !== 16'h7FFF || cap_r0 !== 16'h8000) begin n_bad++; $display("FAIL b2b_peak: got %h/%h want 7fff/8000", cap_l0, cap_r0); end
        n_cmp++; if (rises0 !== base + 4) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", rises0, base + 4); end
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_pulse: got %b want 0", v0); end
        n_cmp++; if (o0 !== 1'b0 || f0 !== 1'b0) begin n_bad++; $display("FAIL b2b_flags: got %b%b want 00", o0, f0); end
    endtask

    task automatic test_backpressure();
        int base;
        ready = 1'b0;
        base = rises0;
        frame(16'h1111, 16'h2222);
        n_cmp++; if (v0 !== 1'b1) begin n_bad++; $display("FAIL bp_valid1: got %b want 1", v0); end
        n_cmp++; if (l0 !== 16'h1111 || r0 !== 16'h2222) begin n_bad++; $display("FAIL bp_data1: got %h/%h want 1111/2222", l0, r0); end
        n_cmp++; if (o0 !== 1'b0) begin n_bad++; $display("FAIL bp_ovf_early: got %b want 0", o0); end
        frame(16'h3333, 16'h4444);
        n_cmp++; if (v0 !== 1'b1) begin n_bad++; $display("FAIL bp_valid2: got %b want 1", v0); end
        n_cmp++; if (l0 !== 16'h1111 || r0 !== 16'h2222) begin n_bad++; $display("FAIL bp_hold: got %h/%h want 1111/2222", l0, r0); end
        n_cmp++; if (o0 !== 1'b1) begin n_bad++; $display("FAIL bp_ovf: got %b want 1", o0); end
        n_cmp++; if (rises0 !== base + 1) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", rises0, base + 1); end
        ready = 1'b1;
        tick(1);
        n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL bp_accept: got %b want 0", v0); end
        n_cmp++; if (o0 !== 1'b1) begin n_bad++; $display("FAIL bp_ovf_sticky: got %b want 1", o0); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        n_cmp++; if (o0 !== 1'b0) begin n_bad++; $display("FAIL bp_clr: got %b want 0", o0); end
    endtask

    task automatic test_short_word();
        int base;
        base = rises0;
        half(1'b1, 16'hFFFF, 0, 10, 10);
        half(1'b0, 16'h1234, 0, 16, 16);
        tick(2);
        n_cmp++; if (f0 !== 1'b1) begin n_bad++; $display("FAIL short_ferr: got %b want 1", f0); end
        n_cmp++; if (rises0 !== base) begin n_bad++; $display("FAIL short_nopub: got %0d want %0d", rises0, base); end
        frame(16'hBEEF, 16'hCAFE);
        tick(2);
        n_cmp++; if (rises0 !== base + 1) begin n_bad++; $display("FAIL short_next_count: got %0d want %0d", rises0, base + 1); end
        n_cmp++; if (cap_l0 !== 16'hBEEF || cap_r0 !== 16'hCAFE) begin n_bad++; $display("FAIL short_next_data: got %h/%h want beef/cafe", cap_l0, cap_r0); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        n_cmp++; if (f0 !== 1'b0) begin n_bad++; $display("FAIL short_clr: got %b want 0", f0); end
    endtask

    task automatic test_i2s();
        int base;
        base = rises1;
        half(1'b1, 16'h8001, 1, 16, 18);
        half(1'b0, 16'h7FFE, 1, 16, 18);
        tick(2);
        n_cmp++; if (rises1 !== base + 1) begin n_bad++; $display("FAIL i2s_count: got %0d want %0d", rises1, base + 1); end
        n_cmp++; if (cap_l1 !== 16'h8001) begin n_bad++; $display("FAIL i2s_l: got %h want 8001", cap_l1); end
        n_cmp++; if (cap_r1 !== 16'h7FFE) begin n_bad++; $display("FAIL i2s_r: got %h want 7ffe", cap_r1); end
    endtask

    task automatic test_reset_midframe();
        int base;
        half(1'b1, 16'hF0F0, 0, 7, 7);
        rst_n = 1'b0;
        tick(2);
        n_cmp++; if (l0 !== 16'h0000 || r0 !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_data: got %h/%h want 0000/0000", l0, r0); end
        n_cmp++; if (v0 !== 1'b0 || o0 !== 1'b0 || f0 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctrl: got %b%b%b want 000", v0, o0, f0); end
        n_cmp++; if (l1 !== 16'h0000 || r1 !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_data1: got %h/%h want 0000/0000", l1, r1); end
        rst_n = 1'b1;
        base = rises0;
        half(1'b1, 16'h0F0F, 0, 9, 9);
        half(1'b0, 16'h1357, 0, 16, 16);
        tick(2);
        n_cmp++; if (rises0 !== base) begin n_bad++; $display("FAIL mid_nopub: got %0d want %0d", rises0, base); end
        n_cmp++; if (f0 !== 1'b0 || o0 !== 1'b0) begin n_bad++; $display("FAIL mid_flags: got %b%b want 00", f0, o0); end
        frame(16'h2468, 16'h9BDF);
        tick(2);
        n_cmp++; if (rises0 !== base + 1) begin n_bad++; $display("FAIL mid_pub_count: got %0d want %0d", rises0, base + 1); end
        n_cmp++; if (cap_l0 !== 16'h2468 || cap_r0 !== 16'h9BDF) begin n_bad++; $display("FAIL mid_pub_data: got %h/%h want 2468/9bdf", cap_l0, cap_r0); end
        n_cmp++; if (f0 !== 1'b0) begin n_bad++; $display("FAIL mid_ferr_after: got %b want 0", f0); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_short_word();
        test_i2s();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
